// File: rtl/tff_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tff_ctrl_pkg
// Shared types and constants for the T-flip-flop counter controller.
//   state_t        : controller state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default counter / limit width in bits
// ---------------------------------------------------------------------------
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : tff_ctrl_pkg

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// A single T flip-flop. The output toggles on a rising clock edge whenever t
// is high.
// Ports:
//   clk   : clock, rising edge active
//   reset : asynchronous active-low reset, clears q to 0
//   t     : toggle enable
//   q     : flip-flop output
// ---------------------------------------------------------------------------
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tff_counter_ctrl
// Sequencing controller for a bank of T flip-flops used as an up-counter.
// A run command (start_valid/start_ready) carries a terminal value; the bank
// counts from 0 up to that value, honouring pause and abort, and the result
// is reported with a done_valid/done_ready handshake.
// Ports:
//   clk          : clock, rising edge active
//   reset        : asynchronous active-low reset
//   start_valid  : run command present
//   start_ready  : command can be accepted (IDLE only)
//   limit        : terminal count, sampled on command acceptance
//   pause        : hold the count while running
//   abort        : terminate the run early
//   count        : current T-flip-flop bank value
//   busy         : high while running
//   done_valid   : completion pending (DONE only)
//   done_ready   : consumer accepts completion
//   aborted      : qualifies done_valid, 1 = run ended by abort
// ---------------------------------------------------------------------------
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             aborted
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             aborted_q, aborted_d;
    logic [WIDTH-1:0] t_d;      // toggle enables driven into the bank
    logic [WIDTH-1:0] t_inc;    // toggle pattern that adds one to count
    logic             at_limit;

    // Increment as toggles: bit i flips when every lower bit is already 1.
    assign t_inc[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_inc
            assign t_inc[gi] = &count[gi-1:0];
        end
    endgenerate

    // The bank itself is the count register.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .t     (t_d[gi]),
                .q     (count[gi])
            );
        end
    endgenerate

    assign at_limit = (count == limit_q);

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        aborted_d = aborted_q;
        t_d       = '0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    limit_d   = limit;
                    aborted_d = 1'b0;
                    state_d   = RUN;
                    // Toggling every set bit clears the bank in one edge.
                    t_d       = count;
                end
            end
            RUN: begin
                // Terminal count outranks abort, so a collision reports a
                // normal completion.
                if (at_limit) begin
                    state_d   = DONE;
                    aborted_d = 1'b0;
                end else if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (!pause) begin
                    t_d = t_inc;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            aborted_q <= aborted_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign done_valid  = (state_q == DONE);
    assign aborted     = aborted_q;

endmodule : tff_counter_ctrl

// File: tb/tb_tff_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tff_counter_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the controller's rules.
// ---------------------------------------------------------------------------
module tb_tff_counter_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] limit;
    logic         pause;
    logic         abort;
    logic [W-1:0] count;
    logic         busy;
    logic         done_valid;
    logic         done_ready;
    logic         aborted;

    int n_checks;
    int n_errors;

    // Behavioural model: phase 0 = idle, 1 = running, 2 = done.
    int m_phase;
    int m_count;
    int m_limit;
    bit m_aborted;

    tff_counter_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .limit       (limit),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_count   = 0;
        m_limit   = 0;
        m_aborted = 0;
    endtask

    // Apply the controller's rules for one rising edge using current inputs.
    task automatic model_edge();
        case (m_phase)
            0: if (start_valid) begin
                m_limit   = int'(limit);
                m_count   = 0;
                m_aborted = 0;
                m_phase   = 1;
            end
            1: begin
                if (m_count == m_limit) begin
                    m_phase   = 2;
                    m_aborted = 0;
                end else if (abort) begin
                    m_phase   = 2;
                    m_aborted = 1;
                end else if (!pause) begin
                    m_count = m_count + 1;
                end
            end
            default: if (done_ready) m_phase = 0;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".count"},       int'(count),       m_count);
        check_val({tag, ".start_ready"}, int'(start_ready), int'(m_phase == 0));
        check_val({tag, ".busy"},        int'(busy),        int'(m_phase == 1));
        check_val({tag, ".done_valid"},  int'(done_valid),  int'(m_phase == 2));
        check_val({tag, ".aborted"},     int'(aborted),     int'(m_aborted));
    endtask

    // One clock edge: update the model, sample the DUT 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Accept a command: present it for one edge, then withdraw.
    task automatic issue(input int lim);
        start_valid = 1'b1;
        limit       = W'(lim);
        tick("accept");
        start_valid = 1'b0;
        limit       = W'($urandom);
    endtask

    task automatic finish_done();
        done_ready = 1'b1;
        tick("release");
        done_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        start_valid = 1'b0;
        limit       = '0;
        pause       = 1'b0;
        abort       = 1'b0;
        done_ready  = 1'b0;
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b1;
        tick("idle");

        // Reset mid-run: async assertion between edges while count = 3.
        issue(5);
        tick("r1");
        tick("r2");
        tick("r3");
        check_val("midrun.count_before", int'(count), 3);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all("async_reset");
        @(negedge clk);
        reset = 1'b1;

        // Nominal run, limit 5: count k after E0+k, done after E0+6.
        issue(5);
        check_val("nominal.k0", int'(count), 0);
        for (int k = 1; k <= 5; k++) begin
            tick("nominal");
            check_val("nominal.k", int'(count), k);
            check_val("nominal.not_done", int'(done_valid), 0);
        end
        tick("nominal");
        check_val("nominal.done", int'(done_valid), 1);
        check_val("nominal.aborted", int'(aborted), 0);
        tick("nominal.hold");
        finish_done();
        check_val("nominal.start_ready", int'(start_ready), 1);

        // Pause two cycles at count 1, limit 3: done after E0+6.
        issue(3);
        tick("pause");
        pause = 1'b1;
        tick("pause");
        tick("pause");
        pause = 1'b0;
        check_val("pause.held", int'(count), 1);
        tick("pause");
        tick("pause");
        check_val("pause.not_done", int'(done_valid), 0);
        tick("pause");
        check_val("pause.done", int'(done_valid), 1);
        check_val("pause.count", int'(count), 3);
        finish_done();

        // limit = 0: done after E0+1 with count 0.
        issue(0);
        tick("zero");
        check_val("zero.done", int'(done_valid), 1);
        check_val("zero.count", int'(count), 0);
        finish_done();

        // Abort at count 4 with limit 10.
        issue(10);
        for (int k = 0; k < 4; k++) tick("abort");
        abort = 1'b1;
        tick("abort");
        abort = 1'b0;
        check_val("abort.done", int'(done_valid), 1);
        check_val("abort.count", int'(count), 4);
        check_val("abort.flag", int'(aborted), 1);
        finish_done();

        // Abort on the same edge the terminal count is reached.
        issue(2);
        tick("collide");
        tick("collide");
        abort = 1'b1;
        tick("collide");
        abort = 1'b0;
        check_val("collide.done", int'(done_valid), 1);
        check_val("collide.flag", int'(aborted), 0);
        finish_done();

        // Full range: limit 255 reaches all-ones, done after E0+256.
        issue(255);
        for (int k = 1; k <= 255; k++) tick("full");
        check_val("full.count", int'(count), 255);
        check_val("full.not_done", int'(done_valid), 0);
        tick("full");
        check_val("full.done", int'(done_valid), 1);
        check_val("full.nowrap", int'(count), 255);
        finish_done();
        check_val("restart.hold", int'(count), 255);
        issue(2);
        check_val("restart.clear", int'(count), 0);
        tick("restart");
        tick("restart");
        tick("restart");
        check_val("restart.done", int'(done_valid), 1);
        check_val("restart.count", int'(count), 2);
        finish_done();

        // start_valid held through RUN and DONE: nothing extra accepted.
        start_valid = 1'b1;
        limit       = W'(3);
        tick("held");
        for (int k = 0; k < 8; k++) begin
            limit = W'($urandom);
            tick("held");
            check_val("held.start_ready", int'(start_ready), 0);
        end
        check_val("held.count", int'(count), 3);
        start_valid = 1'b0;
        finish_done();
        tick("held.idle");
        check_val("held.stay_idle", int'(start_ready), 1);

        // Randomized traffic, all inputs toggling freely.
        for (int c = 0; c < 4000; c++) begin
            start_valid = ($urandom_range(0, 3) == 0);
            limit       = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            pause       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 24) == 0);
            done_ready  = ($urandom_range(0, 1) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tff_counter_ctrl
